// File: rtl/key_scanner.sv
// key_scanner: serial key chain scanner with debounce and event FIFO.
// Auto-repeat events are built only when KEYBOARD_REPEAT_EN is defined.
module key_scanner #(
  parameter int NUM          = 16,
  parameter int CLK_DIV      = 18,
  parameter int DEB          = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8
) (
  input  logic                   clk,
  input  logic                   sclr,
  input  logic                   sdi,
  output logic                   sclk,
  output logic                   load_n,
  input  logic [NUM-1:0]         key_level,
  output logic [NUM-1:0]         key,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [$clog2(NUM)-1:0] ev_code,
  output logic                   ev_press,
  output logic                   ev_repeat,
  output logic                   ev_overflow,
  input  logic                   ev_clr
);
  localparam int CW = $clog2(NUM);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(NUM - 1);
  localparam logic [7:0]    DEB_LAST = 8'(DEB - 1);
`ifdef KEYBOARD_REPEAT_EN
  localparam int EW = CW + 2;
`else
  localparam int EW = CW + 1;
`endif

  if (NUM < 2 || NUM > 32 || CLK_DIV < 1 || DEB < 1 || DEB > 255 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("key_scanner: illegal parameter set");
  end

  typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic [CW-1:0]  bit_q, bit_d;
  logic           half_q, half_d;
  logic [NUM-1:0] raw_q;
  logic           div_end, sample, scan_valid;

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q <= S_LOAD;
      div_q   <= '0;
      bit_q   <= '0;
      half_q  <= 1'b0;
      raw_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      half_q  <= half_d;
      if (sample) raw_q <= {raw_q[NUM-2:0], sdi};
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q + 1'b1;
    bit_d      = bit_q;
    half_d     = half_q;
    div_end    = (div_q == DIV_LAST);
    sample     = 1'b0;
    scan_valid = 1'b0;
    sclk       = 1'b0;
    load_n     = 1'b1;
    unique case (state_q)
      S_LOAD: begin
        load_n = sclr;
        if (div_end) begin
          div_d   = '0;
          half_d  = 1'b0;
          bit_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sclk   = half_q & ~sclr;
        sample = div_end & ~half_q;
        if (div_end) begin
          div_d  = '0;
          half_d = ~half_q;
          if (half_q) begin
            if (bit_q == BIT_LAST) state_d = S_DONE;
            else bit_d = bit_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        scan_valid = 1'b1;
        div_d      = '0;
        state_d    = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  logic [7:0]     cnt_q [NUM];
  logic [7:0]     cnt_d [NUM];
  logic [NUM-1:0] act, accept, key_d;
  logic [NUM-1:0] pend_q, pend_d, ptype_q, ptype_d;
  logic           push;
  logic [CW-1:0]  sel;

  assign act = ~(raw_q ^ key_level);

  always_comb begin
    for (int i = 0; i < NUM; i++)
      accept[i] = scan_valid & (act[i] != key[i]) & (cnt_q[i] == DEB_LAST);
  end

`ifdef KEYBOARD_REPEAT_EN
  localparam logic [15:0] R_DLY  = 16'(REPEAT_DELAY);
  localparam logic [15:0] R_RATE = 16'(REPEAT_RATE);
  logic [15:0]    rcnt_q [NUM];
  logic [15:0]    rcnt_d [NUM];
  logic [NUM-1:0] rph_q, rph_d, fire, rflag_q, rflag_d;

  // rph marks that the initial delay has elapsed; later periods use the rate
  always_comb begin
    rph_d = rph_q;
    fire  = '0;
    for (int i = 0; i < NUM; i++) begin
      rcnt_d[i] = rcnt_q[i];
      if (accept[i]) begin
        rcnt_d[i] = '0;
        rph_d[i]  = 1'b0;
      end else if (scan_valid && key[i]) begin
        if (rcnt_q[i] + 16'd1 == (rph_q[i] ? R_RATE : R_DLY)) begin
          fire[i]   = 1'b1;
          rcnt_d[i] = '0;
          rph_d[i]  = 1'b1;
        end else begin
          rcnt_d[i] = rcnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      rph_q   <= '0;
      rflag_q <= '0;
      for (int i = 0; i < NUM; i++) rcnt_q[i] <= '0;
    end else begin
      rph_q   <= rph_d;
      rflag_q <= rflag_d;
      for (int i = 0; i < NUM; i++) rcnt_q[i] <= rcnt_d[i];
    end
  end
`endif

  always_comb begin
    key_d   = key;
    pend_d  = pend_q;
    ptype_d = ptype_q;
`ifdef KEYBOARD_REPEAT_EN
    rflag_d = rflag_q;
`endif
    push = 1'b0;
    sel  = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        push = 1'b1;
        sel  = CW'(i);
      end
    end
    if (push) pend_d[sel] = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      if (scan_valid) begin
        if (act[i] == key[i]) cnt_d[i] = '0;
        else if (accept[i]) cnt_d[i] = '0;
        else cnt_d[i] = cnt_q[i] + 8'd1;
      end
      if (accept[i]) begin
        key_d[i]   = act[i];
        pend_d[i]  = 1'b1;
        ptype_d[i] = act[i];
`ifdef KEYBOARD_REPEAT_EN
        rflag_d[i] = 1'b0;
      end else if (fire[i]) begin
        pend_d[i]  = 1'b1;
        ptype_d[i] = 1'b1;
        rflag_d[i] = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      key     <= '0;
      pend_q  <= '0;
      ptype_q <= '0;
      for (int i = 0; i < NUM; i++) cnt_q[i] <= '0;
    end else begin
      key     <= key_d;
      pend_q  <= pend_d;
      ptype_q <= ptype_d;
      for (int i = 0; i < NUM; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] ev_in, head;
  logic [AW:0]   wp_q, rp_q;
  logic          empty, full, pop, wr, drop;

`ifdef KEYBOARD_REPEAT_EN
  assign ev_in     = {sel, ptype_q[sel], rflag_q[sel]};
  assign ev_repeat = ~empty & head[0];
`else
  assign ev_in     = {sel, ptype_q[sel]};
  assign ev_repeat = 1'b0;
`endif

  assign empty    = (wp_q == rp_q);
  assign full     = (wp_q[AW] != rp_q[AW]) &&
                    (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop      = ~empty & ev_ready;
  assign wr       = push & (~full | pop);
  assign drop     = push & full & ~pop;
  assign head     = mem_q[rp_q[AW-1:0]];
  assign ev_valid = ~empty;
  assign ev_code  = empty ? '0 : head[EW-1 -: CW];
  assign ev_press = ~empty & head[EW-CW-1];

  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q[AW-1:0]] <= ev_in;
  end

  // a drop in the same cycle as ev_clr keeps the flag set
  always_ff @(posedge clk) begin
    if (sclr) begin
      wp_q        <= '0;
      rp_q        <= '0;
      ev_overflow <= 1'b0;
    end else begin
      if (wr)  wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      ev_overflow <= drop | (ev_overflow & ~ev_clr);
    end
  end

endmodule

// File: tb/tb_key_scanner.sv
// tb_key_scanner: directed self-checking bench for key_scanner.
// Auto-repeat steps run only when KEYBOARD_REPEAT_EN is defined.
module tb_key_scanner;
  logic        clk = 1'b0;
  logic        sclr = 1'b1;
  logic        sdi;
  logic        sclk, load_n;
  logic [15:0] key_level = 16'hFFFF;
  logic [15:0] key;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic [3:0]  ev_code;
  logic        ev_press, ev_repeat, ev_overflow;
  logic        ev_clr = 1'b0;
  logic [15:0] raw = 16'h0000;
  logic [15:0] chain = 16'h0000;
  logic        sclk_d = 1'b0;
  int          passed = 0;
  int          total = 0;

  always #5 clk = ~clk;

  key_scanner #(
    .NUM(16), .CLK_DIV(2), .DEB(3), .FIFO_DEPTH(4),
    .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .sclr(sclr), .sdi(sdi), .sclk(sclk), .load_n(load_n),
    .key_level(key_level), .key(key), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_code(ev_code), .ev_press(ev_press),
    .ev_repeat(ev_repeat), .ev_overflow(ev_overflow), .ev_clr(ev_clr)
  );

  // parallel-in serial-out chain: load while load_n low, shift on sclk rise
  always @(posedge clk) begin
    sclk_d <= sclk;
    if (!load_n) chain <= raw;
    else if (sclk && !sclk_d) chain <= {chain[14:0], 1'b0};
  end
  assign sdi = chain[15];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scan(input int n);
    repeat (n) begin
      int t;
      t = 0;
      while (load_n === 1'b0 && t < 200) begin step(1); t++; end
      while (load_n !== 1'b0 && t < 200) begin step(1); t++; end
      if (t >= 200) begin
        total++;
        $error("FAIL scan_timeout: got %0d cycles expected < 200", t);
      end
    end
  endtask

  task automatic pop(input string tag, input int code,
                     input logic press, input logic rep);
    chk({tag, "_valid"}, ev_valid, 1);
    chk({tag, "_code"}, ev_code, code);
    chk({tag, "_press"}, ev_press, press);
    chk({tag, "_repeat"}, ev_repeat, rep);
    ev_ready = 1'b1;
    step(1);
    ev_ready = 1'b0;
  endtask

  initial begin
    step(3);
    chk("rst_sclk", sclk, 0);
    chk("rst_load_n", load_n, 1);
    chk("rst_key", key, 0);
    chk("rst_valid", ev_valid, 0);
    chk("rst_code", ev_code, 0);
    chk("rst_press", ev_press, 0);
    chk("rst_repeat", ev_repeat, 0);
    chk("rst_ovf", ev_overflow, 0);
    sclr = 1'b0;
    step(1);
    chk("load_after_rst", load_n, 0);
    chk("load_sclk", sclk, 0);

    raw = 16'h0001;
    scan(2);
    step(20);
    chk("mid_shift_load_n", load_n, 1);
    sclr = 1'b1;
    step(1);
    chk("mid_rst_sclk", sclk, 0);
    chk("mid_rst_load_n", load_n, 1);
    chk("mid_rst_key", key, 0);
    chk("mid_rst_valid", ev_valid, 0);
    sclr = 1'b0;
    step(1);
    chk("load_after_mid_rst", load_n, 0);
    scan(1);
    chk("no_deb_after_rst", key, 0);
    raw = 16'h0000;
    scan(1);
    step(4);
    chk("no_event_after_rst", ev_valid, 0);
    scan(1);

    raw = 16'h0020;
    scan(2);
    raw = 16'h0000;
    scan(1);
    chk("deb_short_key", key, 0);
    chk("deb_short_valid", ev_valid, 0);
    raw = 16'h0020;
    scan(2);
    chk("deb_2scans", key, 0);
    scan(1);
    chk("deb_3scans", key, 16'h0020);
    step(3);
    pop("press5", 5, 1'b1, 1'b0);
    chk("press5_empty", ev_valid, 0);
    scan(1);
    raw = 16'h0000;
    scan(3);
    chk("rel5_key", key, 0);
    step(3);
    pop("rel5", 5, 1'b0, 1'b0);
    scan(1);

    raw = 16'h4204;
    scan(3);
    chk("multi_key", key, 16'h4204);
    step(5);
    ev_ready = 1'b1;
    chk("multi_code0", ev_code, 2);
    chk("multi_press0", ev_press, 1);
    step(1);
    chk("multi_code1", ev_code, 9);
    chk("multi_valid1", ev_valid, 1);
    step(1);
    chk("multi_code2", ev_code, 14);
    chk("multi_valid2", ev_valid, 1);
    step(1);
    chk("multi_drained", ev_valid, 0);
    step(1);
    chk("empty_pop_ignored", ev_valid, 0);
    ev_ready = 1'b0;
    scan(1);
    raw = 16'h0000;
    scan(3);
    step(5);
    pop("multi_rel2", 2, 1'b0, 1'b0);
    pop("multi_rel9", 9, 1'b0, 1'b0);
    pop("multi_rel14", 14, 1'b0, 1'b0);
    chk("multi_rel_empty", ev_valid, 0);
    scan(1);

    raw = 16'h00F3;
    scan(3);
    step(10);
    chk("ovf_set", ev_overflow, 1);
    ev_clr = 1'b1;
    step(1);
    ev_clr = 1'b0;
    chk("ovf_clr", ev_overflow, 0);
    pop("ovf_e0", 0, 1'b1, 1'b0);
    pop("ovf_e1", 1, 1'b1, 1'b0);
    pop("ovf_e4", 4, 1'b1, 1'b0);
    pop("ovf_e5", 5, 1'b1, 1'b0);
    chk("ovf_only4", ev_valid, 0);
    scan(1);
    raw = 16'h0000;
    scan(3);
    step(10);
    chk("ovf_set_again", ev_overflow, 1);
    pop("ovf_r0", 0, 1'b0, 1'b0);
    pop("ovf_r1", 1, 1'b0, 1'b0);
    pop("ovf_r4", 4, 1'b0, 1'b0);
    pop("ovf_r5", 5, 1'b0, 1'b0);
    chk("ovf_r_empty", ev_valid, 0);
    chk("ovf_sticky", ev_overflow, 1);
    ev_clr = 1'b1;
    step(1);
    ev_clr = 1'b0;
    chk("ovf_clr2", ev_overflow, 0);
    scan(1);

    key_level = 16'hFFF7;
    raw = 16'h0008;
    scan(1);
    chk("pol_idle", key, 0);
    raw = 16'h0000;
    scan(2);
    chk("pol_2scans", key, 0);
    scan(1);
    chk("pol_press_key", key, 16'h0008);
    step(3);
    pop("pol_press", 3, 1'b1, 1'b0);
    scan(1);
    raw = 16'h0008;
    scan(3);
    chk("pol_rel_key", key, 0);
    step(3);
    pop("pol_rel", 3, 1'b0, 1'b0);
    chk("pol_empty", ev_valid, 0);
    scan(1);
    key_level = 16'hFFFF;
    raw = 16'h0000;
    scan(1);

`ifdef KEYBOARD_REPEAT_EN
    raw = 16'h0002;
    scan(3);
    chk("rep_key", key, 16'h0002);
    step(3);
    pop("rep_press", 1, 1'b1, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      scan(1);
      if (k == 8) raw = 16'h0000;
      step(3);
      if (k == 4 || k == 6 || k == 8 || k == 10)
        pop("rep_ev", 1, 1'b1, 1'b1);
      else if (k == 11)
        pop("rep_rel", 1, 1'b0, 1'b0);
      else
        chk("rep_none", ev_valid, 0);
    end
    chk("rep_key_off", key, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish, %0d/%0d",
             passed, total);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/key_scanner.md
KEY_SCANNER -- requirements
Module: key_scanner

Interface
REQ-001 Parameter NUM, default 16, number of key channels (2..32).
REQ-002 Parameter CLK_DIV, default 18, clk cycles per sclk half-period and per load pulse (>=1).
REQ-003 Parameter DEB, default 8, consecutive differing scans needed to accept a key change (1..255).
REQ-004 Parameter FIFO_DEPTH, default 8, event FIFO entries (power of 2, >=2).
REQ-005 Parameters REPEAT_DELAY, default 32, and REPEAT_RATE, default 8, in scans (>=1); these are used only with KEYBOARD_REPEAT_EN.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 sclr  input  1  synchronous active-high reset.
REQ-008 sdi  input  1  serial data from external parallel-in shift register chain.
REQ-009 sclk  output  1  shift clock to the chain.
REQ-010 load_n  output  1  active-low parallel load to the chain.
REQ-011 key_level  input  NUM  per-channel active level; a raw bit equal to key_level[i] is treated as pressed.
REQ-012 key  output  NUM  debounced state; 1 = pressed.
REQ-013 ev_valid  output  1  event FIFO not empty.
REQ-014 ev_ready  input  1  consumer pop strobe; pop occurs when ev_valid and ev_ready are both high.
REQ-015 ev_code  output  clog2(NUM)  channel index of the head event.
REQ-016 ev_press  output  1  head event type: 1 = press, 0 = release.
REQ-017 ev_repeat  output  1  head event is an auto-repeat.
REQ-018 ev_overflow  output  1  sticky flag; set when an event is dropped.
REQ-019 ev_clr  input  1  clears ev_overflow.

Function
REQ-020 The scan FSM shall cycle LOAD -> SHIFT -> DONE -> LOAD continuously.
REQ-021 LOAD: load_n low and sclk low for CLK_DIV cycles.
REQ-022 SHIFT: load_n high for NUM bits; each bit is sclk low for CLK_DIV cycles, then sclk high for CLK_DIV cycles.
REQ-023 In SHIFT, sdi shall be sampled on the last clk of each sclk-low half; the first sampled bit is raw[NUM-1] (MSB first).
REQ-024 DONE shall last 1 cycle and assert an internal scan_valid strobe; scan period = CLK_DIV*(1+2*NUM)+1 cycles.
REQ-025 Per channel, act[i] = ~(raw[i] ^ key_level[i]).
REQ-026 On each scan_valid, if act[i] != key[i], cnt[i] shall increment; otherwise cnt[i] shall clear.
REQ-027 When cnt[i] would reach DEB, key[i] shall toggle and cnt[i] shall clear in the same cycle (DEB=1: toggle on the first differing scan).
REQ-028 Each key toggle shall set pending[i] with the event type (press on 0->1, release on 1->0).
REQ-029 An event serialiser shall push one pending event per clk into the FIFO, lowest index first; all pending events shall be drained before the next scan_valid.
REQ-030 The FIFO shall be show-ahead: ev_code, ev_press and ev_repeat are valid whenever ev_valid is high.
REQ-031 A push to a full FIFO with a simultaneous pop shall be accepted; without a pop, the event shall be dropped and ev_overflow set.
REQ-032 ev_clr shall clear ev_overflow; if ev_clr coincides with a drop, the flag shall remain set.
REQ-033 A pop on an empty FIFO shall be ignored.

Reset
REQ-034 While sclr is high: sclk=0, load_n=1, key=0, all cnt=0, pending=0, FIFO empty (ev_valid=0, ev_code=0, ev_press=0, ev_repeat=0), ev_overflow=0, and repeat counters=0.
REQ-035 The first cycle after sclr deasserts shall enter LOAD.
REQ-036 An sclr during SHIFT shall discard the partial scan; no debounce update or event shall result from it.

Configuration
REQ-037 With macro KEYBOARD_REPEAT_EN defined, a per-channel scan counter shall run while key[i]=1.
REQ-038 With KEYBOARD_REPEAT_EN, a press event with ev_repeat=1 shall be queued REPEAT_DELAY scans after acceptance, then every REPEAT_RATE scans until release.
REQ-039 Without KEYBOARD_REPEAT_EN, no repeat logic shall be built and ev_repeat shall be constant 0.

Verification (NUM=16, CLK_DIV=2, DEB=3, FIFO_DEPTH=4, key_level=16'hFFFF unless noted)
REQ-040 Reset: assert sclr mid-SHIFT -> next cycle sclk=0, load_n=1, key=0, ev_valid=0; LOAD follows release; no event is produced.
REQ-041 Debounce: raw[5] active for 2 scans, then inactive -> no event. Raw[5] active for 3 scans -> key[5]=1 after the 3rd DONE; one event (code 5, press=1).
REQ-042 Simultaneous changes: keys 2, 9, 14 accepted in the same scan -> pops yield codes 2, 9, 14 in order, on consecutive cycles with ev_ready=1.
REQ-043 Overflow: ev_ready=0, 6 events generated -> 4 stored, ev_overflow=1; pulse ev_clr -> ev_overflow=0; the 4 entries are intact.
REQ-044 Polarity: key_level[3]=0, sdi low in bit 3 for 3 scans -> key[3]=1 and a press event; a release event follows after 3 scans with bit 3 high.
REQ-045 Repeat (KEYBOARD_REPEAT_EN, REPEAT_DELAY=4, REPEAT_RATE=2): hold key 1 -> press event, then repeat events (ev_repeat=1) at scans +4, +6, +8; after release, a release event and no further repeats.
